flip_request_sequencer: RTL and testbench

Drives the per-variable break-data protocol of the variable flip selector for one unsatisfied clause at a time. It accepts a clause's NSAT variable indices and fetches each variable's clause-broken and mask bits from the variable-clause memory. It presents them to the selector over NSAT cycles using the one-hot/all-ones write-enable encoding, then captures the selector's registered choice and returns the chosen variable index with its broken-clause bits over a valid/ready handshake.

---
 rtl/flip_request_sequencer.sv | 105 ++++++++++
 tb/tb_flip_request_sequencer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/flip_request_sequencer.sv
// flip_request_sequencer: fetches a clause's variable break data, streams it to the flip selector
// with the 01/10/11 write-enable encoding, and returns the selector's chosen variable over valid/ready.
module flip_request_sequencer #(
  parameter int NSAT = 3,
  parameter int MAX_CLAUSES_PER_VARIABLE = 20,
  parameter int VAR_BITS = 10
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                req_valid_i,
  output logic                                req_ready_o,
  input  logic [NSAT*VAR_BITS-1:0]            req_vars_i,
  output logic                                mem_rd_en_o,
  output logic [VAR_BITS-1:0]                 mem_addr_o,
  input  logic [2*MAX_CLAUSES_PER_VARIABLE-1:0] mem_rd_data_i,
  output logic [MAX_CLAUSES_PER_VARIABLE-1:0] sel_clause_broken_o,
  output logic [MAX_CLAUSES_PER_VARIABLE-1:0] sel_mask_bits_o,
  output logic [NSAT-1:0]                     sel_valid_o,
  output logic [1:0]                          sel_wren_o,
  input  logic [1:0]                          sel_selected_i,
  input  logic [MAX_CLAUSES_PER_VARIABLE-1:0] sel_broken_bits_i,
  output logic                                flip_valid_o,
  input  logic                                flip_ready_i,
  output logic [VAR_BITS-1:0]                 flip_var_o,
  output logic [MAX_CLAUSES_PER_VARIABLE-1:0] flip_broken_bits_o,
  output logic                                flip_none_o
);
  localparam int MC = MAX_CLAUSES_PER_VARIABLE;
  localparam logic [2:0] IDLE = 3'd0, READ = 3'd1, FLUSH = 3'd2, CAPTURE = 3'd3, OUT = 3'd4;
  if (NSAT != 3) begin : g_bad_nsat
    $error("flip_request_sequencer: NSAT must be 3");
  end
  logic [2:0] state;
  logic [1:0] k, rd_k;
  logic rd_pend, hit;
  logic [NSAT-1:0] nz;
  logic [3:0] vld;
  // Slot 3 is a permanent zero so an out-of-range selector code reads as "no variable".
  logic [3:0][VAR_BITS-1:0] vars;
  for (genvar i = 0; i < NSAT; i++) begin : g_nz
    assign nz[i] = |req_vars_i[i*VAR_BITS +: VAR_BITS];
  end
  assign vld = {1'b0, sel_valid_o};
  assign hit = vld[sel_selected_i];
  assign req_ready_o = state == IDLE;
  assign flip_valid_o = state == OUT;
  assign mem_rd_en_o = state == READ;
  assign mem_addr_o = mem_rd_en_o ? vars[k] : '0;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      k <= '0;
      rd_k <= '0;
      rd_pend <= 1'b0;
      vars <= '0;
      sel_valid_o <= '0;
      sel_clause_broken_o <= '0;
      sel_mask_bits_o <= '0;
      sel_wren_o <= 2'b00;
      flip_var_o <= '0;
      flip_broken_bits_o <= '0;
      flip_none_o <= 1'b0;
    end else begin
      rd_pend <= mem_rd_en_o;
      rd_k <= k;
      sel_wren_o <= rd_pend ? rd_k + 2'd1 : 2'b00;
      if (rd_pend) begin
        sel_clause_broken_o <= mem_rd_data_i[MC-1:0];
        sel_mask_bits_o <= mem_rd_data_i[2*MC-1:MC];
      end
      case (state)
        IDLE: if (req_valid_i) begin
          vars <= {VAR_BITS'(0), req_vars_i};
          sel_valid_o <= nz;
          k <= '0;
          state <= (|nz) ? READ : OUT;
          if (!(|nz)) begin
            flip_var_o <= '0;
            flip_broken_bits_o <= '0;
            flip_none_o <= 1'b1;
          end
        end
        READ: begin
          k <= (k == 2'd2) ? 2'd0 : k + 2'd1;
          state <= (k == 2'd2) ? FLUSH : READ;
        end
        FLUSH: begin
          k <= k + 2'd1;
          state <= (k == 2'd1) ? CAPTURE : FLUSH;
        end
        CAPTURE: begin
          flip_var_o <= hit ? vars[sel_selected_i] : '0;
          flip_broken_bits_o <= hit ? sel_broken_bits_i : '0;
          flip_none_o <= !hit;
          state <= OUT;
        end
        OUT: if (flip_ready_i) begin
          sel_valid_o <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_flip_request_sequencer.sv
// tb_flip_request_sequencer: table-driven requests against memory and selector models,
// plus hand-written stall and mid-operation reset sequences.
module tb_flip_request_sequencer;
  logic clk = 1'b0, reset = 1'b1;
  logic req_valid = 1'b0, flip_ready = 1'b0;
  logic [29:0] req_vars = '0;
  logic [39:0] mem_data = '0;
  logic [1:0] sel_selected = 2'b11, pick = 2'b00;
  logic [19:0] sel_broken = '0;
  logic req_ready_o, mem_rd_en_o, flip_valid_o, flip_none_o;
  logic [9:0] mem_addr_o, flip_var_o;
  logic [19:0] sel_clause_broken_o, sel_mask_bits_o, flip_broken_bits_o;
  logic [2:0] sel_valid_o;
  logic [1:0] sel_wren_o;
  int checks = 0, errors = 0, reads = 0;

  flip_request_sequencer dut (
    .clk(clk), .reset(reset), .req_valid_i(req_valid), .req_ready_o(req_ready_o),
    .req_vars_i(req_vars), .mem_rd_en_o(mem_rd_en_o), .mem_addr_o(mem_addr_o),
    .mem_rd_data_i(mem_data), .sel_clause_broken_o(sel_clause_broken_o),
    .sel_mask_bits_o(sel_mask_bits_o), .sel_valid_o(sel_valid_o), .sel_wren_o(sel_wren_o),
    .sel_selected_i(sel_selected), .sel_broken_bits_i(sel_broken),
    .flip_valid_o(flip_valid_o), .flip_ready_i(flip_ready), .flip_var_o(flip_var_o),
    .flip_broken_bits_o(flip_broken_bits_o), .flip_none_o(flip_none_o)
  );

  always #5 clk = ~clk;

  function automatic logic [39:0] mem_fn(input logic [9:0] a);
    logic [19:0] b;
    b = (a == 10'd5) ? 20'h00003 : (a == 10'd9) ? 20'h00010 : (a == 10'd12) ? 20'h00000 : (20'h80000 | 20'(a));
    return {20'hFFFFF, b};
  endfunction

  always @(posedge clk) if (mem_rd_en_o) begin
    mem_data <= mem_fn(mem_addr_o);
    reads <= reads + 1;
  end

  // Selector model: keeps the broken bits of variable "pick" and reports "pick" after the 11 write.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_selected <= 2'b11;
      sel_broken <= '0;
    end else begin
      if (sel_wren_o != 2'b00 && sel_wren_o - 2'd1 == pick) sel_broken <= sel_clause_broken_o;
      if (sel_wren_o == 2'b11) sel_selected <= pick;
    end
  end

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_valid(output int lat, output logic [23:0] ws);
    lat = 0;
    ws = '0;
    for (int c = 1; c <= 12 && lat == 0; c++) begin
      ws |= 24'(sel_wren_o) << (2 * (c - 1));
      if (flip_valid_o) lat = c;
      else begin
        @(posedge clk); #1;
      end
    end
  endtask

  typedef struct {
    logic [9:0] v0, v1, v2;
    logic [1:0] pick;
    logic early;
    logic [9:0] ev;
    logic [19:0] eb;
    logic en;
  } vec_t;

  task automatic run(input vec_t t);
    int lat, rd0;
    logic [23:0] ws;
    logic [2:0] sv;
    logic z;
    z = ({t.v2, t.v1, t.v0} == '0);
    req_vars = {t.v2, t.v1, t.v0};
    pick = t.pick;
    flip_ready = t.early;
    req_valid = 1'b1;
    chk("req_ready idle", req_ready_o, 1);
    rd0 = reads;
    @(posedge clk); #1;
    req_valid = 1'b0;
    sv = sel_valid_o;
    wait_valid(lat, ws);
    chk("latency", lat, z ? 1 : 7);
    chk("wren seq", ws, z ? 24'h0 : 24'h390);
    chk("mem reads", reads - rd0, z ? 0 : 3);
    chk("sel_valid", sv, {t.v2 != 0, t.v1 != 0, t.v0 != 0});
    chk("flip_var", flip_var_o, t.ev);
    chk("flip_broken", flip_broken_bits_o, t.eb);
    chk("flip_none", flip_none_o, t.en);
    flip_ready = 1'b1;
    @(posedge clk); #1;
    flip_ready = 1'b0;
    chk("after handshake", {flip_valid_o, req_ready_o, sel_valid_o}, 5'b01000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[8];
    int lat;
    logic [23:0] ws;
    tbl[0] = '{10'd5, 10'd9, 10'd12, 2'd2, 1'b0, 10'd12, 20'h00000, 1'b0};
    tbl[1] = '{10'd0, 10'd7, 10'd0, 2'd1, 1'b0, 10'd7, 20'h80007, 1'b0};
    tbl[2] = '{10'd0, 10'd7, 10'd0, 2'd0, 1'b0, 10'd0, 20'h00000, 1'b1};
    tbl[3] = '{10'd0, 10'd0, 10'd0, 2'd1, 1'b0, 10'd0, 20'h00000, 1'b1};
    tbl[4] = '{10'd3, 10'd4, 10'd6, 2'd3, 1'b0, 10'd0, 20'h00000, 1'b1};
    tbl[5] = '{10'd3, 10'd4, 10'd6, 2'd1, 1'b1, 10'd4, 20'h80004, 1'b0};
    tbl[6] = '{10'd1, 10'd0, 10'd1023, 2'd2, 1'b0, 10'd1023, 20'h803FF, 1'b0};
    tbl[7] = '{10'd1, 10'd0, 10'd1023, 2'd1, 1'b0, 10'd0, 20'h00000, 1'b1};
    #12;
    chk("reset outputs", {req_ready_o, flip_valid_o, flip_none_o, mem_rd_en_o, sel_wren_o, sel_valid_o}, 9'b100000000);
    chk("reset data", {flip_var_o, flip_broken_bits_o}, '0);
    reset = 1'b0;
    @(posedge clk); #1;
    // Selector still at its post-reset code 11: no valid choice.
    run('{10'd5, 10'd9, 10'd12, 2'd3, 1'b0, 10'd0, 20'h00000, 1'b1});
    for (int i = 0; i < 8; i++) run(tbl[i]);
    // Stall in OUT with req_valid held high throughout.
    req_vars = {10'd12, 10'd9, 10'd5};
    pick = 2'd2;
    req_valid = 1'b1;
    @(posedge clk); #1;
    wait_valid(lat, ws);
    chk("stall latency", lat, 7);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("stall hold", {flip_valid_o, req_ready_o, flip_none_o, flip_var_o, flip_broken_bits_o}, {3'b100, 10'd12, 20'h0});
    end
    flip_ready = 1'b1;
    @(posedge clk); #1;
    flip_ready = 1'b0;
    chk("ready after handshake", {req_ready_o, flip_valid_o}, 2'b10);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("held req accepted", req_ready_o, 0);
    wait_valid(lat, ws);
    chk("held req latency", lat, 7);
    chk("held req var", flip_var_o, 12);
    flip_ready = 1'b1;
    @(posedge clk); #1;
    flip_ready = 1'b0;
    // Asynchronous reset while wren=10 is presented.
    req_vars = {10'd12, 10'd9, 10'd5};
    pick = 2'd0;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("pre-reset wren", sel_wren_o, 2'b10);
    #1 reset = 1'b1;
    #1;
    chk("async reset", {sel_wren_o, req_ready_o, flip_valid_o, mem_rd_en_o, sel_valid_o}, 8'b00100000);
    #2 reset = 1'b0;
    @(posedge clk); #1;
    chk("post-reset idle", {sel_wren_o, req_ready_o}, 3'b001);
    run('{10'd3, 10'd4, 10'd6, 2'd1, 1'b1, 10'd4, 20'h80004, 1'b0});
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
